reorder_ctrl: RTL and testbench
===============================

Name: reorder_ctrl

Overview:
Sequencer for one delay-commutator `reorder` stage of the SDF FFT pipeline. It drives the commutator `sw` select in lock-step with the sample stream and tracks frame boundaries. After the last sample of a frame it runs a flush segment so the delay line drains. It emits frame markers aligned to the stage output and flags protocol errors.

Parameters:
LENGTH, 7, depth of the controlled reorder delay line; segment length in samples; must be >= 2
FRAME_LEN, 28, samples per frame; must be a multiple of 2*LENGTH

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
din_valid  input  1  sample present at the reorder `din` this cycle
sof  input  1  start of frame; qualified by din_valid
in_ready  output  1  controller can accept a sample this cycle
sw  output  1  commutator select to reorder `sw`; applies to the current-cycle sample
busy  output  1  frame in progress or flush pending
out_sof  output  1  first sample of a frame at reorder `dout` (accepted sof delayed LENGTH)
out_eof  output  1  last sample of a frame at reorder `dout` (accepted last sample delayed LENGTH)
underrun  output  1  sticky: din_valid dropped mid-frame
sof_err  output  1  sticky: sof not at a frame boundary

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, phase=1, seg_cnt=0, frame_cnt=0, marker pipes cleared, underrun=0, sof_err=0.
  - Resulting outputs: sw=1, busy=0, in_ready=1, out_sof=0, out_eof=0.
  - Reset mid-frame or mid-flush aborts immediately; no further markers are emitted.
- Counters:
  - seg_cnt is 0..LENGTH-1, width $clog2(LENGTH).
  - frame_cnt is 0..FRAME_LEN-1, width $clog2(FRAME_LEN).
  - Both wrap to 0; no saturation.
- sw = phase, combinationally, in all states. phase is 1 in IDLE.
- Accept = din_valid && in_ready.
- States:
  - IDLE:
    - in_ready=1.
    - Accept with sof -> RUN. That cycle is sample 0, so seg_cnt=1 and frame_cnt=1.
    - Accept without sof: sample discarded, sof_err set, stay IDLE.
  - RUN:
    - in_ready=1. Each accepted sample increments seg_cnt and frame_cnt.
    - When seg_cnt wraps (LENGTH-1 -> 0), phase toggles. sw is therefore 1 for samples 0..L-1, 0 for L..2L-1, and so on.
    - Last sample (frame_cnt=FRAME_LEN-1) -> FLUSH. phase has toggled to 1 and seg_cnt=0.
    - din_valid=0 in RUN: underrun set; -> IDLE; phase=1; counters and pipes cleared (frame lost).
    - sof with frame_cnt!=0: sof_err set; sample treated as ordinary data.
  - FLUSH:
    - Lasts exactly LENGTH cycles with sw=1, seg_cnt counting every cycle.
    - in_ready=1 only on flush cycle 0 (seg_cnt=0). Accept with sof there is a back-to-back frame: behaves as sample 0, -> RUN, no gap.
    - Accept without sof on cycle 0: sof_err set, sample discarded, flush continues.
    - Flush cycles 1..LENGTH-1: in_ready=0. din_valid there is discarded; sof_err is set if sof is also asserted.
    - After the last flush cycle -> IDLE.
- busy = (state != IDLE).
- Marker pipes:
  - Two LENGTH-deep shift registers shift every clock.
  - Inputs are (accept && sof && starting a frame) and (accept && frame_cnt==FRAME_LEN-1).
  - out_sof and out_eof are the pipe tails, so latency equals the reorder datapath latency of LENGTH.
- Sticky flags clear only on rst.
- Simultaneous events:
  - The underrun check takes priority over sof_err in the same cycle.
  - rst overrides everything.

Decomposition:
- fft_pkg: add `reorder_state_e` (IDLE, RUN, FLUSH) typedef.
- fft_pkg: add a function `reorder_ctrl_params_ok(LENGTH, FRAME_LEN)` used in an elaboration-time assertion.
- Sub-module `marker_delay` (parameter DEPTH, 1-bit shift line, synchronous reset), instantiated twice for out_sof and out_eof.
- The counters and FSM stay in the top module.

Test Plan:
LENGTH=4, FRAME_LEN=16.
1. Single frame: sof plus 16 continuous valid samples -> sw = 1111 0000 1111 0000 on samples 0..15, then 4 flush cycles with sw=1; out_sof at cycle 4, out_eof at cycle 19; busy falls after cycle 19; reorder_ctrl plus reorder reproduces the golden reorder order.
2. Back-to-back: second sof on the cycle after sample 15 -> no flush, sw pattern continuous; out_sof at cycles 4 and 20; no sof_err.
3. Gap: din_valid low at sample 9 -> underrun=1, state IDLE, sw=1; no out_eof for that frame; a later sof frame runs normally with underrun still 1.
4. Misplaced sof: sof asserted at sample 5 -> sof_err=1; frame completes with out_eof at the normal cycle. Separately, data without sof in IDLE -> sof_err=1, busy stays 0.
5. Late frame: sof on flush cycle 2 -> in_ready=0, sample dropped, sof_err=1; flush completes; IDLE at cycle 20.
6. Reset mid-RUN at sample 7 -> next cycle sw=1, busy=0, both flags 0; out_sof/out_eof stay 0 for the next 8 cycles.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the SDF FFT pipeline control logic.
package fft_pkg;

   // Sequencer states for a reorder stage controller
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } reorder_state_e;

   // Legal parameter set: at least two samples per segment, whole segment pairs per frame
   function automatic bit reorder_ctrl_params_ok(input int unsigned length,
                                                 input int unsigned frame_len);
      return (length >= 2) && (frame_len >= 2 * length) &&
             ((frame_len % (2 * length)) == 0);
   endfunction

endpackage

// File: rtl/marker_delay.sv
// Fixed-depth 1-bit delay line used to align frame markers with the reorder datapath.
module marker_delay #(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] line;

   // Shift every clock; synchronous clear drops anything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         line <= '0;
      end else begin
         line <= {line[DEPTH-2:0], din};
      end
   end

   assign dout = line[DEPTH-1];

endmodule

// File: rtl/reorder_ctrl.sv
// Commutator sequencer for one SDF reorder stage: sw select, frame tracking,
// flush of the delay line, aligned frame markers and sticky protocol errors.
module reorder_ctrl
   import fft_pkg::*;
#(
   parameter int unsigned LENGTH    = 7,
   parameter int unsigned FRAME_LEN = 28
) (
   input  logic clk,
   input  logic rst,
   input  logic din_valid,
   input  logic sof,
   output logic in_ready,
   output logic sw,
   output logic busy,
   output logic out_sof,
   output logic out_eof,
   output logic underrun,
   output logic sof_err
);

   localparam int unsigned SEG_W = $clog2(LENGTH);
   localparam int unsigned FRM_W = $clog2(FRAME_LEN);
   localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(LENGTH - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_LEN - 1);

   if (!reorder_ctrl_params_ok(LENGTH, FRAME_LEN)) begin : g_bad_params
      $error("reorder_ctrl: LENGTH must be >= 2 and FRAME_LEN a multiple of 2*LENGTH");
   end

   reorder_state_e   state, state_n;
   logic             phase, phase_n;
   logic [SEG_W-1:0] seg_cnt, seg_n;
   logic [FRM_W-1:0] frame_cnt, frame_n;
   logic             underrun_n, sof_err_n;
   logic             drop;
   logic             accept;
   logic             start_mark;
   logic             last_mark;
   logic             pipe_clr;

   // State register and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         phase     <= 1'b1;
         seg_cnt   <= '0;
         frame_cnt <= '0;
         underrun  <= 1'b0;
         sof_err   <= 1'b0;
      end else begin
         state     <= state_n;
         phase     <= phase_n;
         seg_cnt   <= seg_n;
         frame_cnt <= frame_n;
         underrun  <= underrun_n;
         sof_err   <= sof_err_n;
      end
   end

   // Next-state, counter and flag update
   always_comb begin
      state_n    = state;
      phase_n    = phase;
      seg_n      = seg_cnt;
      frame_n    = frame_cnt;
      underrun_n = underrun;
      sof_err_n  = sof_err;
      drop       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (sof) begin
                  state_n = RUN;
                  seg_n   = SEG_W'(1);
                  frame_n = FRM_W'(1);
               end else begin
                  sof_err_n = 1'b1;
               end
            end
         end
         RUN: begin
            if (!din_valid) begin
               underrun_n = 1'b1;
               state_n    = IDLE;
               phase_n    = 1'b1;
               seg_n      = '0;
               frame_n    = '0;
               drop       = 1'b1;
            end else begin
               if (sof && (frame_cnt != '0)) begin
                  sof_err_n = 1'b1;
               end
               if (seg_cnt == SEG_LAST) begin
                  seg_n   = '0;
                  phase_n = ~phase;
               end else begin
                  seg_n = seg_cnt + SEG_W'(1);
               end
               if (frame_cnt == FRM_LAST) begin
                  frame_n = '0;
                  state_n = FLUSH;
               end else begin
                  frame_n = frame_cnt + FRM_W'(1);
               end
            end
         end
         FLUSH: begin
            if (accept && sof) begin
               state_n = RUN;
               seg_n   = SEG_W'(1);
               frame_n = FRM_W'(1);
            end else begin
               if (din_valid && (sof || in_ready)) begin
                  sof_err_n = 1'b1;
               end
               if (seg_cnt == SEG_LAST) begin
                  seg_n   = '0;
                  state_n = IDLE;
               end else begin
                  seg_n = seg_cnt + SEG_W'(1);
               end
            end
         end
         default: begin
            state_n = IDLE;
            phase_n = 1'b1;
            seg_n   = '0;
            frame_n = '0;
         end
      endcase
   end

   // Handshake, select and marker inputs decoded from registered state
   always_comb begin
      in_ready   = (state != FLUSH) || (seg_cnt == '0);
      sw         = phase;
      busy       = (state != IDLE);
      accept     = din_valid && in_ready;
      start_mark = accept && sof && (state != RUN);
      last_mark  = accept && (frame_cnt == FRM_LAST);
      pipe_clr   = rst || drop;
   end

   marker_delay #(.DEPTH(LENGTH)) u_sof_delay (
      .clk  (clk),
      .rst  (pipe_clr),
      .din  (start_mark),
      .dout (out_sof)
   );

   marker_delay #(.DEPTH(LENGTH)) u_eof_delay (
      .clk  (clk),
      .rst  (pipe_clr),
      .din  (last_mark),
      .dout (out_eof)
   );

endmodule

// File: tb/tb_reorder_ctrl.sv
// Scoreboard bench for reorder_ctrl with LENGTH=4, FRAME_LEN=16.
module tb_reorder_ctrl;

   localparam int unsigned L = 4;
   localparam int unsigned F = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din_valid = 1'b0;
   logic sof = 1'b0;
   logic in_ready, sw, busy, out_sof, out_eof, underrun, sof_err;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int cyc;
      bit s;
      bit e;
   } mk_t;

   mk_t exp_q[$];

   reorder_ctrl #(.LENGTH(L), .FRAME_LEN(F)) dut (
      .clk       (clk),
      .rst       (rst),
      .din_valid (din_valid),
      .sof       (sof),
      .in_ready  (in_ready),
      .sw        (sw),
      .busy      (busy),
      .out_sof   (out_sof),
      .out_eof   (out_eof),
      .underrun  (underrun),
      .sof_err   (sof_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: every marker the DUT presents must match the next expected one
   always @(negedge clk) begin
      mk_t m;
      if (out_sof === 1'b1 || out_eof === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected marker", 1'b1, 1'b0);
         end else begin
            m = exp_q.pop_front();
            chk_int("marker cycle", cyc, m.cyc);
            chk("marker out_sof", out_sof, m.s);
            chk("marker out_eof", out_eof, m.e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      din_valid = 1'b0;
      sof = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Send samples 0..n-1 of a frame; sof also raised at bad_sof_at (if >= 0)
   task automatic frame(input int n, input int bad_sof_at, input string nm);
      int t0;
      t0 = cyc;
      for (int i = 0; i < n; i++) begin
         din_valid = 1'b1;
         sof = (i == 0) || (i == bad_sof_at);
         #1;
         chk({nm, " sw"}, sw, ((i / L) % 2) == 0);
         chk({nm, " in_ready"}, in_ready, 1'b1);
         if (i == 0 && n >= int'(L)) exp_q.push_back(mk_t'{t0 + int'(L), 1'b1, 1'b0});
         if (i == int'(F) - 1) exp_q.push_back(mk_t'{t0 + int'(F) - 1 + int'(L), 1'b0, 1'b1});
         tick();
      end
      din_valid = 1'b0;
      sof = 1'b0;
   endtask

   // Walk the flush segment, optionally presenting a sample at cycle stray_at
   task automatic flush(input int stray_at, input bit stray_sof, input string nm);
      for (int k = 0; k < int'(L); k++) begin
         din_valid = (k == stray_at);
         sof = stray_sof && (k == stray_at);
         #1;
         chk({nm, " flush sw"}, sw, 1'b1);
         chk({nm, " flush busy"}, busy, 1'b1);
         chk({nm, " flush in_ready"}, in_ready, k == 0);
         tick();
      end
      din_valid = 1'b0;
      sof = 1'b0;
      chk({nm, " busy after flush"}, busy, 1'b0);
      chk({nm, " sw after flush"}, sw, 1'b1);
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("reset sw", sw, 1'b1);
      chk("reset busy", busy, 1'b0);
      chk("reset in_ready", in_ready, 1'b1);
      chk("reset out_sof", out_sof, 1'b0);
      chk("reset out_eof", out_eof, 1'b0);
      chk("reset underrun", underrun, 1'b0);
      chk("reset sof_err", sof_err, 1'b0);

      // 1. Single frame then flush
      frame(16, -1, "single");
      flush(-1, 1'b0, "single");
      chk("single underrun", underrun, 1'b0);
      chk("single sof_err", sof_err, 1'b0);

      // 2. Back-to-back frames
      do_reset();
      frame(16, -1, "b2b_a");
      frame(16, -1, "b2b_b");
      flush(-1, 1'b0, "b2b");
      chk("b2b sof_err", sof_err, 1'b0);

      // 3. Gap at sample 9, then a normal frame
      do_reset();
      frame(9, -1, "gap");
      tick();
      chk("gap underrun", underrun, 1'b1);
      chk("gap busy", busy, 1'b0);
      chk("gap sw", sw, 1'b1);
      chk("gap in_ready", in_ready, 1'b1);
      repeat (2) tick();
      frame(16, -1, "after_gap");
      flush(-1, 1'b0, "after_gap");
      chk("after_gap underrun sticky", underrun, 1'b1);
      chk("after_gap sof_err", sof_err, 1'b0);

      // 3b. Gap early enough that the start marker is still in flight
      do_reset();
      frame(2, -1, "early_gap");
      tick();
      chk("early_gap underrun", underrun, 1'b1);
      repeat (L + 2) begin
         tick();
         chk("early_gap out_sof", out_sof, 1'b0);
      end

      // 4. Misplaced sof at sample 5
      do_reset();
      frame(16, 5, "missof");
      flush(-1, 1'b0, "missof");
      chk("missof sof_err", sof_err, 1'b1);
      chk("missof underrun", underrun, 1'b0);

      // 4b. Data without sof in IDLE
      do_reset();
      din_valid = 1'b1;
      sof = 1'b0;
      tick();
      din_valid = 1'b0;
      chk("idle_data sof_err", sof_err, 1'b1);
      chk("idle_data busy", busy, 1'b0);

      // 5. Late sof on flush cycle 2 is dropped
      do_reset();
      frame(16, -1, "late");
      flush(2, 1'b1, "late");
      chk("late sof_err", sof_err, 1'b1);

      // 5b. Data without sof on flush cycle 0 is dropped, flush continues
      do_reset();
      frame(16, -1, "flush0");
      flush(0, 1'b0, "flush0");
      chk("flush0 sof_err", sof_err, 1'b1);

      // 6. Reset mid-RUN at sample 7 clears flags set earlier
      do_reset();
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      chk("pre_rst sof_err", sof_err, 1'b1);
      frame(7, -1, "rst7");
      rst = 1'b1;
      din_valid = 1'b1;
      tick();
      rst = 1'b0;
      din_valid = 1'b0;
      chk("rst7 sw", sw, 1'b1);
      chk("rst7 busy", busy, 1'b0);
      chk("rst7 underrun", underrun, 1'b0);
      chk("rst7 sof_err", sof_err, 1'b0);
      repeat (8) begin
         chk("rst7 out_sof", out_sof, 1'b0);
         chk("rst7 out_eof", out_eof, 1'b0);
         tick();
      end

      // 6b. Reset at sample 2 drops the in-flight start marker
      frame(2, -1, "rst2");
      rst = 1'b1;
      din_valid = 1'b1;
      tick();
      rst = 1'b0;
      din_valid = 1'b0;
      repeat (8) begin
         chk("rst2 out_sof", out_sof, 1'b0);
         tick();
      end

      chk_int("markers outstanding", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
